// File: rtl/dfilt_out_fifo.sv
// Output stage of a sigma-delta filter channel: strobe edge detect, shift/saturate to OUT_W,
// then a show-ahead FIFO or a single bypass holding register, with overflow and clip flags.
module dfilt_out_fifo #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 16,
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic             SYSCLK,
   input  logic             SYSRST,
   input  logic             reg_filten,
   input  logic             reg_fifoen,
   input  logic [LW-1:0]    reg_fifoilvl,
   input  logic [4:0]       reg_filtsh,
   input  logic             reg_sat,
   input  logic             filt_osr,
   input  logic [IN_W-1:0]  filt_data_in,
   input  logic             fifo_rd,
   input  logic             fifo_ovf_clr,
   output logic [OUT_W-1:0] filt_data_out,
   output logic             filt_data_update,
   output logic [LW-1:0]    fifo_stat,
   output logic             fifo_lvlup,
   output logic             fifo_full,
   output logic             fifo_ovf,
   output logic             sat_event
);

   localparam int PW = $clog2(DEPTH);
   localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic                  osr_s1, osr_s2, osr_s3;
   logic                  fifoen_q;
   logic [OUT_W-1:0]      mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [LW-1:0]         count;
   logic [OUT_W-1:0]      hold;
   logic                  hold_vld;

   logic                  upd, flush, full_i, push, pop, byp_wr, ovf_set;
   logic [4:0]            sh;
   logic signed [IN_W-1:0] v;
   logic [OUT_W-1:0]      sample;
   logic                  clip;

   assign upd    = osr_s2 & ~osr_s3 & reg_filten;
   assign flush  = (reg_fifoen != fifoen_q) | ~reg_filten;
   assign full_i = (count == LW'(DEPTH));

   always_comb begin
      sh = reg_filtsh;
      if (int'(reg_filtsh) > IN_W - 1) sh = 5'(IN_W - 1);
   end

   always_comb begin
      v      = $signed(filt_data_in) >>> sh;
      sample = v[OUT_W-1:0];
      clip   = 1'b0;
      if (reg_sat) begin
         if (v > SAT_MAX) begin
            sample = SAT_MAX[OUT_W-1:0];
            clip   = 1'b1;
         end else if (v < SAT_MIN) begin
            sample = SAT_MIN[OUT_W-1:0];
            clip   = 1'b1;
         end
      end
   end

   // A full FIFO still accepts a sample when a read frees the head slot in the same cycle.
   assign push    = upd & ~flush & reg_fifoen & (~full_i | fifo_rd);
   assign pop     = ~flush & reg_fifoen & fifo_rd & (count != '0);
   assign byp_wr  = upd & ~flush & ~reg_fifoen;
   assign ovf_set = upd & ~flush & ~fifo_rd & (reg_fifoen ? full_i : hold_vld);

   always_ff @(posedge SYSCLK) begin
      if (SYSRST) begin
         osr_s1    <= 1'b0;
         osr_s2    <= 1'b0;
         osr_s3    <= 1'b0;
         fifoen_q  <= 1'b0;
         sat_event <= 1'b0;
         fifo_ovf  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         hold      <= '0;
         hold_vld  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         osr_s1    <= filt_osr;
         osr_s2    <= osr_s1;
         osr_s3    <= osr_s2;
         fifoen_q  <= reg_fifoen;
         sat_event <= (push | byp_wr) & clip;
         if (ovf_set)           fifo_ovf <= 1'b1;
         else if (fifo_ovf_clr) fifo_ovf <= 1'b0;
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= sample;
               wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + LW'(1);
               2'b01:   count <= count - LW'(1);
               default: count <= count;
            endcase
            if (byp_wr) begin
               hold     <= sample;
               hold_vld <= 1'b1;
            end else if (~reg_fifoen & fifo_rd) begin
               hold_vld <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      filt_data_update = upd;
      filt_data_out    = '0;
      fifo_stat        = '0;
      fifo_lvlup       = 1'b0;
      fifo_full        = 1'b0;
      if (reg_fifoen) begin
         fifo_stat  = count;
         fifo_full  = full_i;
         fifo_lvlup = (reg_fifoilvl != '0) && (count >= reg_fifoilvl);
         if (reg_filten && count != '0) filt_data_out = mem[rd_ptr];
      end else begin
         fifo_stat = {{(LW-1){1'b0}}, hold_vld};
         if (reg_filten) filt_data_out = hold;
      end
   end

endmodule

// File: tb/tb_dfilt_out_fifo.sv
// Scoreboard bench for dfilt_out_fifo: samples expected from a reference shift/saturate model
// are queued on each strobe and compared against the show-ahead head on every read.
module tb_dfilt_out_fifo;

   logic        SYSCLK = 1'b0;
   logic        SYSRST = 1'b1;
   logic        reg_filten = 1'b0;
   logic        reg_fifoen = 1'b0;
   logic [4:0]  reg_fifoilvl = '0;
   logic [4:0]  reg_filtsh = '0;
   logic        reg_sat = 1'b0;
   logic        filt_osr = 1'b0;
   logic [31:0] filt_data_in = '0;
   logic        fifo_rd = 1'b0;
   logic        fifo_ovf_clr = 1'b0;
   logic [15:0] filt_data_out;
   logic        filt_data_update;
   logic [4:0]  fifo_stat;
   logic        fifo_lvlup, fifo_full, fifo_ovf, sat_event;

   always #5 SYSCLK = ~SYSCLK;

   dfilt_out_fifo dut (
      .SYSCLK(SYSCLK), .SYSRST(SYSRST), .reg_filten(reg_filten), .reg_fifoen(reg_fifoen),
      .reg_fifoilvl(reg_fifoilvl), .reg_filtsh(reg_filtsh), .reg_sat(reg_sat),
      .filt_osr(filt_osr), .filt_data_in(filt_data_in), .fifo_rd(fifo_rd),
      .fifo_ovf_clr(fifo_ovf_clr), .filt_data_out(filt_data_out),
      .filt_data_update(filt_data_update), .fifo_stat(fifo_stat), .fifo_lvlup(fifo_lvlup),
      .fifo_full(fifo_full), .fifo_ovf(fifo_ovf), .sat_event(sat_event)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] sbq[$];
   logic        exp_ovf = 1'b0;
   logic        exp_vld = 1'b0;
   logic [15:0] exp_hold = '0;
   logic        exp_sat = 1'b0;
   logic        last_sat, last_upd;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   function automatic logic [16:0] model(input logic [31:0] d, input int sh, input logic sat);
      int v;
      int s;
      s = (sh > 31) ? 31 : sh;
      v = $signed(d) >>> s;
      if (sat && v > 32767)  return {1'b1, 16'h7fff};
      if (sat && v < -32768) return {1'b1, 16'h8000};
      return {1'b0, v[15:0]};
   endfunction

   task automatic chk_fifo(input string tag);
      chk({tag, "_stat"}, 32'(fifo_stat), 32'(sbq.size()));
      chk({tag, "_full"}, 32'(fifo_full), 32'(sbq.size() == 16));
      chk({tag, "_ovf"},  32'(fifo_ovf),  32'(exp_ovf));
      chk({tag, "_out"},  32'(filt_data_out), (sbq.size() > 0) ? 32'(sbq[0]) : 32'h0);
   endtask

   // One osr rise; optional read/ovf-clear pulses land in the same cycle as the update pulse.
   task automatic strobe(input logic [31:0] d, input logic rd, input logic clr);
      logic [16:0] m;
      logic        set;
      m = model(d, int'(reg_filtsh), reg_sat);
      if (rd && reg_fifoen && sbq.size() > 0) chk("rdupd_head", 32'(filt_data_out), 32'(sbq[0]));
      filt_data_in = d;
      filt_osr     = 1'b1;
      @(posedge SYSCLK); #1;
      chk("upd_early", 32'(filt_data_update), 32'h0);
      filt_osr = 1'b0;
      @(posedge SYSCLK); #1;
      last_upd     = filt_data_update;
      fifo_rd      = rd;
      fifo_ovf_clr = clr;
      @(posedge SYSCLK); #1;
      fifo_rd      = 1'b0;
      fifo_ovf_clr = 1'b0;
      last_sat     = sat_event;
      chk("upd_pulse", 32'(last_upd), 32'(reg_filten));
      set     = 1'b0;
      exp_sat = 1'b0;
      if (reg_filten) begin
         if (reg_fifoen) begin
            if (rd && sbq.size() > 0) void'(sbq.pop_front());
            if (sbq.size() < 16) begin
               sbq.push_back(m[15:0]);
               exp_sat = m[16];
            end else set = 1'b1;
         end else begin
            set      = exp_vld & ~rd;
            exp_vld  = 1'b1;
            exp_hold = m[15:0];
            exp_sat  = m[16];
         end
      end
      exp_ovf = set ? 1'b1 : (clr ? 1'b0 : exp_ovf);
   endtask

   task automatic rd_pop(input string tag);
      if (sbq.size() > 0) chk(tag, 32'(filt_data_out), 32'(sbq[0]));
      fifo_rd = 1'b1;
      @(posedge SYSCLK); #1;
      fifo_rd = 1'b0;
      if (sbq.size() > 0) void'(sbq.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge SYSCLK);
      #1;
      chk("rst_out", 32'(filt_data_out), 32'h0);
      chk("rst_stat", 32'(fifo_stat), 32'h0);
      chk("rst_ovf", 32'(fifo_ovf), 32'h0);
      chk("rst_sat", 32'(sat_event), 32'h0);
      SYSRST     = 1'b0;
      reg_filten = 1'b1;
      reg_fifoen = 1'b1;
      reg_filtsh = 5'd4;
      reg_sat    = 1'b1;
      repeat (2) @(posedge SYSCLK);
      #1;

      // basic shift
      strobe(32'h0000_1234, 1'b0, 1'b0);
      chk("t1_out_lit", 32'(filt_data_out), 32'h0123);
      chk_fifo("t1");
      rd_pop("t1_pop");
      chk_fifo("t1_empty");

      // saturation and truncation
      reg_filtsh = 5'd0;
      strobe(32'h0010_0000, 1'b0, 1'b0);
      chk("t2_pos_lit", 32'(filt_data_out), 32'h7fff);
      chk("t2_pos_sat", 32'(last_sat), 32'(exp_sat));
      chk("t2_sat_pulse", 32'(last_sat), 32'h1);
      rd_pop("t2_pos_pop");
      strobe(32'hfff0_0000, 1'b0, 1'b0);
      chk("t2_neg_lit", 32'(filt_data_out), 32'h8000);
      chk("t2_neg_sat", 32'(last_sat), 32'(exp_sat));
      rd_pop("t2_neg_pop");
      reg_sat = 1'b0;
      strobe(32'h0010_0000, 1'b0, 1'b0);
      chk("t2_trunc_lit", 32'(filt_data_out), 32'h0000);
      chk("t2_trunc_sat", 32'(last_sat), 32'h0);
      rd_pop("t2_trunc_pop");
      reg_sat = 1'b0;
      strobe(32'hffff_8001, 1'b0, 1'b0);
      rd_pop("t2_inrange_pop");

      // fill past full
      reg_sat    = 1'b1;
      reg_filtsh = 5'd3;
      for (int i = 0; i < 17; i++) begin
         strobe($urandom(), 1'b0, 1'b0);
         if (i == 15) chk_fifo("t3_16");
      end
      chk_fifo("t3_17");
      chk("t3_ovf_lit", 32'(fifo_ovf), 32'h1);
      strobe($urandom(), 1'b0, 1'b1);
      chk_fifo("t3_clr_set");
      fifo_ovf_clr = 1'b1;
      @(posedge SYSCLK); #1;
      fifo_ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      chk_fifo("t3_clr");

      // full: read and write in the same cycle
      strobe(32'h0012_3450, 1'b1, 1'b0);
      chk_fifo("t4_rdupd");
      chk("t4_stat_lit", 32'(fifo_stat), 32'd16);
      while (sbq.size() > 0) rd_pop("t4_drain");
      chk_fifo("t4_drained");
      rd_pop("t4_empty_rd");
      chk_fifo("t4_empty_after_rd");
      strobe(32'h0000_0a50, 1'b1, 1'b0);
      chk_fifo("t4_empty_rdupd");

      // interrupt level
      rd_pop("t5_pre");
      reg_fifoilvl = 5'd4;
      for (int i = 0; i < 4; i++) begin
         strobe($urandom(), 1'b0, 1'b0);
         chk("t5_lvlup", 32'(fifo_lvlup), 32'(sbq.size() >= 4));
      end
      chk_fifo("t5_four");
      reg_fifoilvl = 5'd0;
      @(posedge SYSCLK); #1;
      chk("t5_lvl_off", 32'(fifo_lvlup), 32'h0);
      reg_fifoen = 1'b0;
      @(posedge SYSCLK); #1;
      sbq.delete();
      chk("t5_flush_stat", 32'(fifo_stat), 32'h0);
      chk("t5_flush_out", 32'(filt_data_out), 32'h0);

      // bypass register
      strobe(32'h0000_1110, 1'b0, 1'b0);
      chk("t6_first_out", 32'(filt_data_out), 32'(exp_hold));
      chk("t6_first_ovf", 32'(fifo_ovf), 32'(exp_ovf));
      strobe(32'h0000_2220, 1'b0, 1'b0);
      chk("t6_ovf", 32'(fifo_ovf), 32'(exp_ovf));
      chk("t6_ovf_lit", 32'(fifo_ovf), 32'h1);
      chk("t6_out", 32'(filt_data_out), 32'(exp_hold));
      chk("t6_stat", 32'(fifo_stat), 32'h1);
      chk("t6_full", 32'(fifo_full), 32'h0);
      fifo_rd = 1'b1;
      @(posedge SYSCLK); #1;
      fifo_rd = 1'b0;
      exp_vld = 1'b0;
      chk("t6_rd_stat", 32'(fifo_stat), 32'h0);
      chk("t6_rd_out", 32'(filt_data_out), 32'(exp_hold));

      // disabled channel
      reg_filten = 1'b0;
      #1;
      chk("t7_dis_out", 32'(filt_data_out), 32'h0);
      strobe(32'h0000_4440, 1'b0, 1'b0);
      chk("t7_dis_stat", 32'(fifo_stat), 32'h0);
      chk("t7_dis_sat", 32'(last_sat), 32'h0);

      reg_filten = 1'b1;
      strobe(32'h0000_5550, 1'b0, 1'b0);
      SYSRST = 1'b1;
      @(posedge SYSCLK); #1;
      chk("t6_rst_stat", 32'(fifo_stat), 32'h0);
      chk("t6_rst_out", 32'(filt_data_out), 32'h0);
      chk("t6_rst_ovf", 32'(fifo_ovf), 32'h0);
      chk("t6_rst_upd", 32'(filt_data_update), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
